multicycle_ctrl: RTL and testbench

Multicycle sequencer for the LEGv8 subset datapath (LDUR, STUR, ADDI, ADDS, SUBS, AND, EOR, LSR, B, CBZ, B.LT). It replaces single-cycle decode with an FSM that steps one shared ALU, register file and memory port through FETCH/DECODE/EXEC/MEM/WB. It owns the NZVC flag register and handshakes with memory via req/ready. It sits between the instruction register/memory interface and the datapath muxes.

---
 rtl/legv8_pkg.sv | 66 ++++++
 rtl/multicycle_ctrl_if.sv | 44 ++++
 rtl/legv8_decode.sv | 27 ++
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/legv8_pkg.sv
// Shared opcode patterns, ALU encodings, FSM states and flag positions for
// the LEGv8 multicycle sequencer.
package legv8_pkg;

  // 11-bit opcode field instr[31:21]; shorter opcodes are matched through masks
  localparam logic [10:0] OP_LDUR   = 11'h7C2;
  localparam logic [10:0] OP_STUR   = 11'h7C0;
  localparam logic [10:0] OP_ADDS   = 11'h558;
  localparam logic [10:0] OP_SUBS   = 11'h758;
  localparam logic [10:0] OP_AND    = 11'h450;
  localparam logic [10:0] OP_EOR    = 11'h650;
  localparam logic [10:0] OP_LSR    = 11'h69A;
  localparam logic [10:0] OP_ADDI   = 11'h488;
  localparam logic [10:0] OP_B      = 11'h0A0;
  localparam logic [10:0] OP_CBZ    = 11'h5A0;
  localparam logic [10:0] OP_BCOND  = 11'h2A0;

  localparam logic [10:0] MASK_FULL = 11'h7FF;
  localparam logic [10:0] MASK_ADDI = 11'h7FE;
  localparam logic [10:0] MASK_B    = 11'h7E0;
  localparam logic [10:0] MASK_CB   = 11'h7F8;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_XOR   = 3'b110,
    ALU_LSR   = 3'b111
  } alu_op_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_C = 0;

  typedef struct packed {
    logic ldur;
    logic stur;
    logic addi;
    logic adds;
    logic subs;
    logic and_op;
    logic eor;
    logic lsr;
    logic b;
    logic cbz;
    logic blt;
  } iclass_t;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == (pat & mask);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle sequencer and the LEGv8 datapath /
// memory port. The sequencer is the master.
interface multicycle_ctrl_if
  import legv8_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
);
  logic [31:0]         instr;
  logic                alu_zero;
  logic                alu_negative;
  logic                alu_overflow;
  logic                alu_carry;
  logic                mem_ready;
  logic                imem_req;
  logic                ir_load;
  logic                dmem_req;
  logic                dmem_we;
  logic                reg2loc;
  logic                alu_src;
  alu_op_t             alu_op;
  logic                mem_to_reg;
  logic                reg_write;
  logic                pc_write;
  logic                pc_src;
  logic                uncond_br;
  logic [3:0]          flags_q;
  logic                illegal;
  logic                retired;
  logic [RETIRE_W-1:0] retire_count;

  modport master (
    input  instr, alu_zero, alu_negative, alu_overflow, alu_carry, mem_ready,
    output imem_req, ir_load, dmem_req, dmem_we, reg2loc, alu_src, alu_op,
           mem_to_reg, reg_write, pc_write, pc_src, uncond_br, flags_q,
           illegal, retired, retire_count
  );

  modport slave (
    output instr, alu_zero, alu_negative, alu_overflow, alu_carry, mem_ready,
    input  imem_req, ir_load, dmem_req, dmem_we, reg2loc, alu_src, alu_op,
           mem_to_reg, reg_write, pc_write, pc_src, uncond_br, flags_q,
           illegal, retired, retire_count
  );
endinterface

// File: rtl/legv8_decode.sv
// Combinational opcode classifier: instruction-class one-hot plus an
// undefined-opcode flag.
module legv8_decode
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output iclass_t     cls,
  output logic        illegal
);

  always_comb begin
    cls        = '0;
    cls.ldur   = op_match(opcode, OP_LDUR,  MASK_FULL);
    cls.stur   = op_match(opcode, OP_STUR,  MASK_FULL);
    cls.adds   = op_match(opcode, OP_ADDS,  MASK_FULL);
    cls.subs   = op_match(opcode, OP_SUBS,  MASK_FULL);
    cls.and_op = op_match(opcode, OP_AND,   MASK_FULL);
    cls.eor    = op_match(opcode, OP_EOR,   MASK_FULL);
    cls.lsr    = op_match(opcode, OP_LSR,   MASK_FULL);
    cls.addi   = op_match(opcode, OP_ADDI,  MASK_ADDI);
    cls.b      = op_match(opcode, OP_B,     MASK_B);
    cls.cbz    = op_match(opcode, OP_CBZ,   MASK_CB);
    cls.blt    = op_match(opcode, OP_BCOND, MASK_CB);
    illegal    = ~(|cls);
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the shared
// datapath, plus the NZVC flag register, undefined-opcode trap and retire counter.
module multicycle_ctrl
  import legv8_pkg::*;
#(
  parameter int unsigned RETIRE_W = 16
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  state_t              state_q, state_d;
  iclass_t             dec_cls, cls_q;
  logic                dec_illegal;
  logic [3:0]          flags_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] count_q;

  logic    imem_req_c, ir_load_c, dmem_req_c, dmem_we_c;
  logic    reg2loc_c, alu_src_c, mem_to_reg_c, reg_write_c;
  logic    pc_write_c, pc_src_c, uncond_br_c, retired_c;
  alu_op_t alu_op_c;
  logic    alu_class;

  legv8_decode u_decode (
    .opcode  (bus.instr[31:21]),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  assign alu_class = cls_q.addi | cls_q.adds | cls_q.subs |
                     cls_q.and_op | cls_q.eor | cls_q.lsr;

  // Strobes are forced low during the reset cycle regardless of the current state.
  always_comb begin
    state_d      = state_q;
    imem_req_c   = 1'b0;
    ir_load_c    = 1'b0;
    dmem_req_c   = 1'b0;
    dmem_we_c    = 1'b0;
    reg2loc_c    = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = ALU_PASSB;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = 1'b0;
    uncond_br_c  = 1'b0;
    retired_c    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        ST_FETCH: begin
          imem_req_c = 1'b1;
          if (bus.mem_ready) begin
            ir_load_c = 1'b1;
            state_d   = ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_d = dec_illegal ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          if (alu_class) begin
            reg2loc_c = ~cls_q.addi;
            alu_src_c = cls_q.addi | cls_q.lsr;
            if (cls_q.subs)        alu_op_c = ALU_SUB;
            else if (cls_q.and_op) alu_op_c = ALU_AND;
            else if (cls_q.eor)    alu_op_c = ALU_XOR;
            else if (cls_q.lsr)    alu_op_c = ALU_LSR;
            else                   alu_op_c = ALU_ADD;
            state_d = ST_WB;
          end else if (cls_q.ldur | cls_q.stur) begin
            alu_src_c = 1'b1;
            alu_op_c  = ALU_ADD;
            state_d   = ST_MEM;
          end else if (cls_q.cbz) begin
            pc_write_c = 1'b1;
            pc_src_c   = bus.alu_zero;
            retired_c  = 1'b1;
            state_d    = ST_FETCH;
          end else if (cls_q.b) begin
            pc_write_c  = 1'b1;
            pc_src_c    = 1'b1;
            uncond_br_c = 1'b1;
            retired_c   = 1'b1;
            state_d     = ST_FETCH;
          end else if (cls_q.blt) begin
            pc_write_c = 1'b1;
            pc_src_c   = flags_q[FLAG_N] ^ flags_q[FLAG_V];
            retired_c  = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_TRAP;
          end
        end
        ST_MEM: begin
          dmem_req_c = 1'b1;
          dmem_we_c  = cls_q.stur;
          alu_src_c  = 1'b1;
          alu_op_c   = ALU_ADD;
          if (bus.mem_ready) begin
            if (cls_q.stur) begin
              pc_write_c = 1'b1;
              retired_c  = 1'b1;
              state_d    = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_write_c  = 1'b1;
          mem_to_reg_c = cls_q.ldur;
          pc_write_c   = 1'b1;
          retired_c    = 1'b1;
          state_d      = ST_FETCH;
        end
        ST_TRAP: begin
          state_d = ST_TRAP;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cls_q     <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q <= state_d;
      // The class is captured once so later states do not depend on instr staying stable.
      if (state_q == ST_DECODE) begin
        cls_q <= dec_cls;
        if (dec_illegal) illegal_q <= 1'b1;
      end
      if (state_q == ST_EXEC && (cls_q.adds || cls_q.subs)) begin
        flags_q <= {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
      end
      if (retired_c) count_q <= count_q + RETIRE_W'(1);
    end
  end

  assign bus.imem_req     = imem_req_c;
  assign bus.ir_load      = ir_load_c;
  assign bus.dmem_req     = dmem_req_c;
  assign bus.dmem_we      = dmem_we_c;
  assign bus.reg2loc      = reg2loc_c;
  assign bus.alu_src      = alu_src_c;
  assign bus.alu_op       = alu_op_c;
  assign bus.mem_to_reg   = mem_to_reg_c;
  assign bus.reg_write    = reg_write_c;
  assign bus.pc_write     = pc_write_c;
  assign bus.pc_src       = pc_src_c;
  assign bus.uncond_br    = uncond_br_c;
  assign bus.retired      = retired_c;
  assign bus.flags_q      = flags_q;
  assign bus.illegal      = illegal_q;
  assign bus.retire_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-by-cycle scoreboard bench for multicycle_ctrl: each scheduled
// instruction pushes its expected per-cycle control vector, flags and count.
module tb_multicycle_ctrl;
  import legv8_pkg::*;

  localparam int unsigned RW = 4;
  localparam logic [2:0] A_PASSB = 3'b000;
  localparam logic [2:0] A_ADD   = 3'b010;
  localparam logic [2:0] A_SUB   = 3'b011;
  localparam logic [2:0] A_AND   = 3'b100;
  localparam logic [2:0] A_XOR   = 3'b110;
  localparam logic [2:0] A_LSR   = 3'b111;

  typedef enum {K_LDUR, K_STUR, K_ADDI, K_ADDS, K_SUBS, K_AND, K_EOR, K_LSR,
                K_B, K_CBZ, K_BLT} kind_e;

  typedef struct packed {
    logic imem_req, ir_load, dmem_req, dmem_we, reg2loc, alu_src;
    logic [2:0] alu_op;
    logic mem_to_reg, reg_write, pc_write, pc_src, uncond_br, retired, illegal;
  } ctrl_t;

  typedef struct {
    logic [31:0]   instr;
    logic          mem_ready;
    logic [3:0]    nzvc;
    ctrl_t         c;
    logic [3:0]    flags;
    logic [RW-1:0] cnt;
  } step_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.RETIRE_W(RW)) bus ();
  multicycle_ctrl #(.RETIRE_W(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  step_t         sb[$];
  logic [3:0]    m_flags;
  logic [RW-1:0] m_cnt;
  int            n_cmp = 0;
  int            n_fail = 0;

  function automatic ctrl_t got();
    ctrl_t g;
    g.imem_req = bus.imem_req;   g.ir_load    = bus.ir_load;
    g.dmem_req = bus.dmem_req;   g.dmem_we    = bus.dmem_we;
    g.reg2loc  = bus.reg2loc;    g.alu_src    = bus.alu_src;
    g.alu_op   = bus.alu_op;     g.mem_to_reg = bus.mem_to_reg;
    g.reg_write = bus.reg_write; g.pc_write   = bus.pc_write;
    g.pc_src   = bus.pc_src;     g.uncond_br  = bus.uncond_br;
    g.retired  = bus.retired;    g.illegal    = bus.illegal;
    return g;
  endfunction

  function automatic logic [31:0] enc(input kind_e k);
    case (k)
      K_LDUR:  return 32'hF8400020;
      K_STUR:  return 32'hF8000020;
      K_ADDI:  return 32'h91000420;
      K_ADDS:  return 32'hAB020020;
      K_SUBS:  return 32'hEB020020;
      K_AND:   return 32'h8A020020;
      K_EOR:   return 32'hCA020020;
      K_LSR:   return 32'hD3400820;
      K_B:     return 32'h14000010;
      K_CBZ:   return 32'hB4000040;
      K_BLT:   return 32'h5400000B;
      default: return 32'h00000000;
    endcase
  endfunction

  // Expected behaviour per cycle; fw/mw are memory wait cycles in FETCH/MEM.
  task automatic sched(input kind_e k, input int fw, input int mw, input logic [3:0] nzvc);
    step_t s;
    ctrl_t c;
    s.instr = enc(k); s.nzvc = nzvc; s.flags = m_flags; s.cnt = m_cnt;
    for (int i = 0; i <= fw; i++) begin
      c = '0; c.imem_req = 1'b1; c.ir_load = (i == fw);
      s.c = c; s.mem_ready = (i == fw); sb.push_back(s);
    end
    s.c = '0; s.mem_ready = 1'b1; sb.push_back(s);
    c = '0;
    case (k)
      K_ADDI: begin c.alu_src = 1'b1; c.alu_op = A_ADD; end
      K_ADDS: begin c.reg2loc = 1'b1; c.alu_op = A_ADD; end
      K_SUBS: begin c.reg2loc = 1'b1; c.alu_op = A_SUB; end
      K_AND:  begin c.reg2loc = 1'b1; c.alu_op = A_AND; end
      K_EOR:  begin c.reg2loc = 1'b1; c.alu_op = A_XOR; end
      K_LSR:  begin c.reg2loc = 1'b1; c.alu_src = 1'b1; c.alu_op = A_LSR; end
      K_LDUR, K_STUR: begin c.alu_src = 1'b1; c.alu_op = A_ADD; end
      K_CBZ:  begin c.pc_write = 1'b1; c.pc_src = nzvc[2]; c.retired = 1'b1; end
      K_B:    begin c.pc_write = 1'b1; c.pc_src = 1'b1; c.uncond_br = 1'b1; c.retired = 1'b1; end
      K_BLT:  begin c.pc_write = 1'b1; c.pc_src = m_flags[3] ^ m_flags[1]; c.retired = 1'b1; end
      default: c.alu_op = A_PASSB;
    endcase
    s.c = c; sb.push_back(s);
    if (k == K_ADDS || k == K_SUBS) m_flags = nzvc;
    s.flags = m_flags;
    if (c.retired) begin
      m_cnt = m_cnt + 1'b1;
      return;
    end
    if (k == K_LDUR || k == K_STUR) begin
      for (int i = 0; i <= mw; i++) begin
        c = '0; c.dmem_req = 1'b1; c.dmem_we = (k == K_STUR);
        c.alu_src = 1'b1; c.alu_op = A_ADD;
        if (i == mw && k == K_STUR) begin c.pc_write = 1'b1; c.retired = 1'b1; end
        s.c = c; s.mem_ready = (i == mw); sb.push_back(s);
      end
      if (k == K_STUR) begin
        m_cnt = m_cnt + 1'b1;
        return;
      end
    end
    c = '0; c.reg_write = 1'b1; c.mem_to_reg = (k == K_LDUR);
    c.pc_write = 1'b1; c.retired = 1'b1;
    s.c = c; s.mem_ready = 1'b1; sb.push_back(s);
    m_cnt = m_cnt + 1'b1;
  endtask

  task automatic test_reset();
    ctrl_t g;
    @(posedge clk); #1;
    reset = 1'b1; bus.mem_ready = 1'b1;
    #3;
    g = got(); g.illegal = 1'b0;
    n_cmp++;
    if (g !== ctrl_t'(0)) begin
      n_fail++;
      $display("FAIL reset_strobes: got %h, want 0", g);
    end
    m_flags = '0; m_cnt = '0; sb.delete();
  endtask

  task automatic test_alu_ops();
    step_t s; ctrl_t g;
    sched(K_ADDS, 0, 0, 4'b1001);
    sched(K_ADDI, 0, 0, 4'b0110);
    sched(K_AND,  0, 0, 4'b0100);
    sched(K_EOR,  0, 0, 4'b1111);
    sched(K_LSR,  0, 0, 4'b0010);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL alu_ops #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_blt();
    step_t s; ctrl_t g;
    sched(K_SUBS, 0, 0, 4'b1000);
    sched(K_BLT,  0, 0, 4'b0000);
    sched(K_SUBS, 0, 0, 4'b1010);
    sched(K_BLT,  0, 0, 4'b0101);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL blt #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_cbz();
    step_t s; ctrl_t g;
    sched(K_CBZ, 0, 0, 4'b1111);
    sched(K_CBZ, 0, 0, 4'b0000);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL cbz #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_mem();
    step_t s; ctrl_t g;
    sched(K_LDUR, 0, 3, 4'b0000);
    sched(K_STUR, 0, 0, 4'b0100);
    sched(K_STUR, 1, 2, 4'b1000);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL mem #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s; ctrl_t g;
    sched(K_ADDI, 2, 0, 4'b0000);
    sched(K_B,    0, 0, 4'b0000);
    sched(K_ADDS, 1, 0, 4'b0111);
    sched(K_LDUR, 2, 1, 4'b1111);
    sched(K_CBZ,  1, 0, 4'b0100);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL back_to_back #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_wrap();
    step_t s; ctrl_t g;
    for (int i = 0; i < 17; i++) sched(K_B, 0, 0, 4'b0000);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL wrap #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    step_t s; ctrl_t g;
    sched(K_LDUR, 0, 3, 4'b0000);
    repeat (5) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL mid_mem_pre #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b1; bus.mem_ready = 1'b0;
    #3; n_cmp++;
    if ({bus.dmem_req, bus.reg_write, bus.pc_write, bus.imem_req} !== 4'b0000) begin
      n_fail++;
      $display("FAIL mid_mem_reset_cycle: got dmem_req/reg_write/pc_write/imem_req=%b, want 0000",
               {bus.dmem_req, bus.reg_write, bus.pc_write, bus.imem_req});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #3; n_cmp++;
    if ({bus.imem_req, bus.dmem_req, bus.reg_write, bus.flags_q, bus.retire_count} !==
        {1'b1, 1'b0, 1'b0, 4'b0000, RW'(0)}) begin
      n_fail++;
      $display("FAIL mid_mem_after: got imem=%b dmem=%b rw=%b flags=%b cnt=%0d, want imem=1 dmem=0 rw=0 flags=0000 cnt=0",
               bus.imem_req, bus.dmem_req, bus.reg_write, bus.flags_q, bus.retire_count);
    end
    m_flags = '0; m_cnt = '0;
    sched(K_ADDS, 0, 0, 4'b0110);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL mid_mem_resume #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s; ctrl_t c; ctrl_t g;
    s.instr = 32'h0000_0000; s.nzvc = 4'b1111; s.flags = m_flags; s.cnt = m_cnt;
    c = '0; c.imem_req = 1'b1; c.ir_load = 1'b1;
    s.c = c; s.mem_ready = 1'b1; sb.push_back(s);
    s.c = '0; sb.push_back(s);
    c = '0; c.illegal = 1'b1; s.c = c;
    repeat (20) sb.push_back(s);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL illegal #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
    test_reset();
    sched(K_B, 0, 0, 4'b0000);
    while (sb.size() > 0) begin
      s = sb.pop_front();
      @(posedge clk); #1;
      reset = 1'b0; bus.instr = s.instr; bus.mem_ready = s.mem_ready;
      {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = s.nzvc;
      #3; g = got(); n_cmp++;
      if ({g, bus.flags_q, bus.retire_count} !== {s.c, s.flags, s.cnt}) begin
        n_fail++;
        $display("FAIL illegal_recover #%0d: got ctrl=%h flags=%b cnt=%0d, want ctrl=%h flags=%b cnt=%0d",
                 n_cmp, g, bus.flags_q, bus.retire_count, s.c, s.flags, s.cnt);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.instr = '0;
    bus.mem_ready = 1'b0;
    {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry} = 4'b0000;
    m_flags = '0;
    m_cnt = '0;
    test_reset();
    test_alu_ops();
    test_blt();
    test_cbz();
    test_mem();
    test_back_to_back();
    test_wrap();
    test_reset_mid_mem();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
